sphn_paddle_bank: RTL and testbench
===================================

// Module: sphn_paddle_bank
// PURPOSE
//  N-channel paddle position engine for the pong game core; replaces fixed two-player paddle logic.
//  Once per frame it updates every paddle from its up/down buttons, or from a ball-tracking AI if that channel is inactive.
//  One time-multiplexed update datapath walks the channels after each frame tick.
//  Outputs feed the VGA renderer and the collision logic; all logic is in the pixel clock domain.
// PARAMETERS
//  NUM_PADDLES  2    number of paddle channels, 1..8
//  Y_W          10   width of vertical coordinates
//  SCREEN_H     480  visible lines; paddle top range is 0..SCREEN_H-PADDLE_H
//  PADDLE_H     64   paddle height in lines; must be < SCREEN_H, which must be < 2**Y_W
//  SPEED        4    lines per frame moved by a human-driven paddle
//  AI_SPEED     3    maximum lines per frame moved by an AI-driven paddle
// PORTS
//  pix_clk      in   1            pixel clock
//  pix_rst      in   1            asynchronous, active-high reset
//  i_frame_tick in   1            1-cycle pulse at start of vblank
//  i_up         in   NUM_PADDLES  move-up buttons, asynchronous, one per channel
//  i_down       in   NUM_PADDLES  move-down buttons, asynchronous
//  i_active     in   NUM_PADDLES  1 = human-controlled, 0 = AI-controlled (synchronised)
//  i_ball_y     in   Y_W          ball centre line, sampled on i_frame_tick
//  o_paddle_y   out  NUM_PADDLES*Y_W  paddle top lines, channel k at [k*Y_W +: Y_W]
//  o_moving     out  NUM_PADDLES  channel moved in the last update
//  o_busy       out  1            update sweep in progress
//  o_overrun    out  1            sticky: i_frame_tick arrived while busy
// BEHAVIOUR
//  Reset: all o_paddle_y = (SCREEN_H-PADDLE_H)/2; o_moving, o_busy and o_overrun = 0; FSM = IDLE.
//  Input sync: i_up, i_down and i_active pass through 2-flop synchronisers; 2-cycle latency before they are visible.
//  FSM IDLE: on i_frame_tick, latch i_ball_y and the synchronised inputs, set ch=0, go to SWEEP.
//  FSM SWEEP: each cycle, write one channel: ch++. After channel NUM_PADDLES-1, return to IDLE.
//  o_busy = (state==SWEEP). Channel k's new position is visible at cycle tick+2+k.
//  Frame tick while in SWEEP: the tick is ignored and o_overrun is set. o_overrun clears only on reset.
//  Human channel, up&~down: y = max(0, y-step).
//  Human channel, down&~up: y = min(SCREEN_H-PADDLE_H, y+step).
//  Human channel, both or neither pressed: y holds.
//  AI channel: target = clamp(ball_y - PADDLE_H/2, 0, SCREEN_H-PADDLE_H).
//  AI channel: y moves toward target by min(AI_SPEED, |target-y|); the paddle never overshoots.
//  Arithmetic: use a signed Y_W+2-bit intermediate so underflow and overflow clamp and never wrap.
//  o_moving[k] = 1 iff the new y differs from the old y; updated in the same cycle as y.
//  Reset mid-sweep: all state returns to reset values immediately; no partial update survives.
// CONFIGURATION
//  SPHN_PADDLE_ACCEL_EN defined:
//   - Each channel keeps a hold counter, 0..SPEED.
//   - It increments once per frame while the same direction is held, and clears on release or reversal.
//   - Human step = SPEED + hold counter, so the step ramps up to 2*SPEED.
//  SPHN_PADDLE_ACCEL_EN undefined: human step = SPEED always; no hold counters are built.
//  AI behaviour is identical in both builds.
// STRUCTURE
//  Package sphn_pong_pkg:
//   - FSM state encoding IDLE/SWEEP.
//   - Direction encoding NONE/UP/DOWN.
//   - Default SCREEN_H/PADDLE_H constants shared with the renderer and collision logic.
//  Sub-module sphn_sync2: parametrised-width 2-flop synchroniser, instanced once for {i_up, i_down, i_active}.
//  Position registers are a flat array indexed by ch; a single clamp/step datapath is shared by all channels.
// TESTING
//  Reset: release pix_rst with defaults -> all o_paddle_y=208, o_busy=0, o_overrun=0.
//  Human move: ch0 active, hold i_up[0], 3 ticks -> y0 = 208,204,200,196; o_moving[0]=1.
//  Both buttons: ch0 active, i_up[0]=i_down[0]=1 -> y0 holds and o_moving[0]=0.
//  Clamp: ch1 active, y1=414, hold i_down[1] for 3 ticks -> y1=416, then 416, 416.
//  Clamp: hold i_up[1] from y=2 -> y1=0, never wraps to a large value.
//  AI: ch1 inactive, i_ball_y=100 from y1=208 -> target 68; y1 steps 205,202,... and settles exactly at 68.
//  Overrun and latency: tick, tick again 1 cycle later (NUM_PADDLES=4) -> o_overrun=1, second tick ignored.
//   Also check channel k updates at tick+2+k.
//  ACCEL_EN build: hold i_down[0] from 208 -> 212,217,223,230,238,246.
//  Reset asserted mid-SWEEP -> all y=208, FSM in IDLE.

Source files
------------

// File: rtl/sphn_pong_pkg.sv
// Shared types and constants for the pong game core.
//   - state_t : sweep FSM encoding (IDLE / SWEEP)
//   - dir_t   : paddle direction encoding (NONE / UP / DOWN)
//   - DEF_SCREEN_H / DEF_PADDLE_H : default geometry that is shared with the
//     renderer and the collision logic
package sphn_pong_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_PADDLE_H = 64;

endpackage

// File: rtl/sphn_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk_i  in  1  destination clock
//   rst_i  in  1  asynchronous active-high reset (both stages clear to 0)
//   d_i    in  W  asynchronous inputs
//   q_o    out W  synchronised outputs, two clock edges behind d_i
module sphn_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sphn_paddle_bank.sv
// N-channel paddle position engine. On each frame tick the FSM snapshots the
// synchronised buttons, the human/AI selects and the ball line, then walks the
// channels one per clock through a single shared step/clamp datapath.
//
// Optional build macro: SPHN_PADDLE_ACCEL_EN adds a per-channel hold counter
// that ramps the human step from SPEED up to 2*SPEED while a direction is held.
//
// Ports:
//   pix_clk      in   1                pixel clock
//   pix_rst      in   1                asynchronous active-high reset
//   i_frame_tick in   1                one-cycle pulse at start of vblank
//   i_up         in   NUM_PADDLES      move-up buttons (asynchronous)
//   i_down       in   NUM_PADDLES      move-down buttons (asynchronous)
//   i_active     in   NUM_PADDLES      1 = human, 0 = AI (asynchronous)
//   i_ball_y     in   Y_W              ball centre line, sampled on the tick
//   o_paddle_y   out  NUM_PADDLES*Y_W  paddle top lines, channel k at [k*Y_W +: Y_W]
//   o_moving     out  NUM_PADDLES      channel position changed on its last update
//   o_busy       out  1                update sweep in progress
//   o_overrun    out  1                sticky: a tick arrived while busy
//   o_dbg_state  out  state_t          current FSM state, for observation
//
// Interface note: i_frame_tick is a fire-and-forget pulse with no ready; a
// tick seen while SWEEP is running is dropped and recorded in o_overrun.
module sphn_paddle_bank
  import sphn_pong_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int Y_W         = 10,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int SPEED       = 4,
  parameter int AI_SPEED    = 3
) (
  input  logic                       pix_clk,
  input  logic                       pix_rst,
  input  logic                       i_frame_tick,
  input  logic [NUM_PADDLES-1:0]     i_up,
  input  logic [NUM_PADDLES-1:0]     i_down,
  input  logic [NUM_PADDLES-1:0]     i_active,
  input  logic [Y_W-1:0]             i_ball_y,
  output logic [NUM_PADDLES*Y_W-1:0] o_paddle_y,
  output logic [NUM_PADDLES-1:0]     o_moving,
  output logic                       o_busy,
  output logic                       o_overrun,
  output state_t                     o_dbg_state
);

  localparam int CH_W = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
  // Two extra bits: one for the sign, one for headroom above SCREEN_H.
  localparam int S_W  = Y_W + 2;

  localparam logic [Y_W-1:0]        Y_RST   = Y_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic signed [S_W-1:0] ZERO_S  = '0;
  localparam logic signed [S_W-1:0] YMAX_S  = S_W'(SCREEN_H - PADDLE_H);
  localparam logic signed [S_W-1:0] HALF_S  = S_W'(PADDLE_H / 2);
  localparam logic signed [S_W-1:0] AI_S    = S_W'(AI_SPEED);
  localparam logic signed [S_W-1:0] SPEED_S = S_W'(SPEED);
  localparam logic [CH_W-1:0]       CH_LAST = CH_W'(NUM_PADDLES - 1);

  // Synchronised button / mode inputs.
  logic [NUM_PADDLES-1:0] up_s, down_s, act_s;

  sphn_sync2 #(.W(3 * NUM_PADDLES)) u_sync (
    .clk_i (pix_clk),
    .rst_i (pix_rst),
    .d_i   ({i_up, i_down, i_active}),
    .q_o   ({up_s, down_s, act_s})
  );

  // FSM and frame snapshot.
  state_t                 state_q;
  logic [CH_W-1:0]        ch_q;
  logic [Y_W-1:0]         ball_q;
  logic [NUM_PADDLES-1:0] up_q, down_q, act_q;
  logic [Y_W-1:0]         pos_q [NUM_PADDLES];
  logic [NUM_PADDLES-1:0] moving_q;
  logic                   overrun_q;

`ifdef SPHN_PADDLE_ACCEL_EN
  localparam int HOLD_W = $clog2(SPEED + 1);
  logic [HOLD_W-1:0] hold_q [NUM_PADDLES];
  dir_t              dir_q  [NUM_PADDLES];
  logic [HOLD_W-1:0] hold_d;
`endif

  // Shared datapath for the channel selected by ch_q.
  logic [Y_W-1:0]        cur_y;
  logic signed [S_W-1:0] y_s, tgt_s, diff_s, step_s, sum_s;
  logic [Y_W-1:0]        pos_d;
  dir_t                  dir_d;

  always_comb begin
    cur_y = pos_q[ch_q];
    y_s   = $signed({2'b00, cur_y});

    dir_d = DIR_NONE;
    if (up_q[ch_q] && !down_q[ch_q]) begin
      dir_d = DIR_UP;
    end else if (down_q[ch_q] && !up_q[ch_q]) begin
      dir_d = DIR_DOWN;
    end

`ifdef SPHN_PADDLE_ACCEL_EN
    // The counter only grows while the same direction stays held across
    // frames; it saturates at SPEED so the step tops out at 2*SPEED.
    hold_d = '0;
    if (act_q[ch_q] && (dir_d != DIR_NONE) && (dir_d == dir_q[ch_q])) begin
      hold_d = (hold_q[ch_q] == HOLD_W'(SPEED)) ? hold_q[ch_q] : hold_q[ch_q] + 1'b1;
    end
    step_s = SPEED_S + $signed(S_W'(hold_d));
`else
    step_s = SPEED_S;
`endif

    // AI target: paddle centred on the ball, kept on screen.
    tgt_s = $signed({2'b00, ball_q}) - HALF_S;
    if (tgt_s < ZERO_S) begin
      tgt_s = ZERO_S;
    end else if (tgt_s > YMAX_S) begin
      tgt_s = YMAX_S;
    end
    diff_s = tgt_s - y_s;

    sum_s = y_s;
    if (act_q[ch_q]) begin
      case (dir_d)
        DIR_UP:   sum_s = y_s - step_s;
        DIR_DOWN: sum_s = y_s + step_s;
        default:  sum_s = y_s;
      endcase
      if (sum_s < ZERO_S) begin
        sum_s = ZERO_S;
      end else if (sum_s > YMAX_S) begin
        sum_s = YMAX_S;
      end
    end else begin
      // Within AI_SPEED of the target we land on it exactly, so no overshoot.
      if (diff_s > AI_S) begin
        sum_s = y_s + AI_S;
      end else if (diff_s < -AI_S) begin
        sum_s = y_s - AI_S;
      end else begin
        sum_s = tgt_s;
      end
    end

    // sum_s is clamped to 0..SCREEN_H-PADDLE_H, so truncation is lossless.
    pos_d = Y_W'(sum_s);
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      ball_q    <= '0;
      up_q      <= '0;
      down_q    <= '0;
      act_q     <= '0;
      moving_q  <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_PADDLES; k++) begin
        pos_q[k] <= Y_RST;
`ifdef SPHN_PADDLE_ACCEL_EN
        hold_q[k] <= '0;
        dir_q[k]  <= DIR_NONE;
`endif
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_frame_tick) begin
            ball_q  <= i_ball_y;
            up_q    <= up_s;
            down_q  <= down_s;
            act_q   <= act_s;
            ch_q    <= '0;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (i_frame_tick) begin
            overrun_q <= 1'b1;
          end
          pos_q[ch_q]    <= pos_d;
          moving_q[ch_q] <= (pos_d != cur_y);
`ifdef SPHN_PADDLE_ACCEL_EN
          hold_q[ch_q] <= hold_d;
          dir_q[ch_q]  <= act_q[ch_q] ? dir_d : DIR_NONE;
`endif
          if (ch_q == CH_LAST) begin
            ch_q    <= '0;
            state_q <= ST_IDLE;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_out
    assign o_paddle_y[g*Y_W +: Y_W] = pos_q[g];
  end

  assign o_moving    = moving_q;
  assign o_busy      = (state_q == ST_SWEEP);
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sphn_paddle_bank.sv
module tb_sphn_paddle_bank;
  import sphn_pong_pkg::*;

  localparam int NP       = 4;
  localparam int Y_W      = 10;
  localparam int SH       = 480;
  localparam int PH       = 64;
  localparam int SPEED    = 4;
  localparam int AI_SPEED = 3;
  localparam int YMAX     = SH - PH;
  localparam int YRST     = YMAX / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                tick   = 1'b0;
  logic [NP-1:0]       up     = '0;
  logic [NP-1:0]       down   = '0;
  logic [NP-1:0]       active = '0;
  logic [Y_W-1:0]      ball   = '0;
  logic [NP*Y_W-1:0]   paddle_y;
  logic [NP-1:0]       moving;
  logic                busy;
  logic                overrun;
  state_t              dbg_state;

  int total = 0;
  int bad   = 0;

  logic [Y_W-1:0] exp_q[$];

  sphn_paddle_bank #(
    .NUM_PADDLES (NP),
    .Y_W         (Y_W),
    .SCREEN_H    (SH),
    .PADDLE_H    (PH),
    .SPEED       (SPEED),
    .AI_SPEED    (AI_SPEED)
  ) dut (
    .pix_clk      (clk),
    .pix_rst      (rst),
    .i_frame_tick (tick),
    .i_up         (up),
    .i_down       (down),
    .i_active     (active),
    .i_ball_y     (ball),
    .o_paddle_y   (paddle_y),
    .o_moving     (moving),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_dbg_state  (dbg_state)
  );

  function automatic int y_of(int k);
    return int'(paddle_y[k*Y_W +: Y_W]);
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Positions per channel; a tick sampled at edge e0 schedules channel k's new
  // value to appear after edge e0+1+k. Buttons reach the FSM two edges late.
  int            m_y[NP], nxt_y[NP], m_hold[NP], m_dir[NP];
  bit            m_mov[NP], nxt_mov[NP];
  bit            m_ovr, sweeping;
  int            e, e0;
  logic [NP-1:0] up_h1, up_h2, dn_h1, dn_h2, ac_h1, ac_h2;

  task automatic plan_frame();
    int y, ny, tgt, dir, stp;
    for (int k = 0; k < NP; k++) begin
      y = m_y[k];
      if (ac_h2[k]) begin
        dir = (up_h2[k] && !dn_h2[k]) ? 1 : (dn_h2[k] && !up_h2[k]) ? 2 : 0;
        stp = SPEED;
`ifdef SPHN_PADDLE_ACCEL_EN
        if (dir != 0 && dir == m_dir[k]) m_hold[k] = (m_hold[k] < SPEED) ? m_hold[k] + 1 : SPEED;
        else m_hold[k] = 0;
        m_dir[k] = dir;
        stp = SPEED + m_hold[k];
`endif
        if (dir == 1) ny = (y - stp < 0) ? 0 : y - stp;
        else if (dir == 2) ny = (y + stp > YMAX) ? YMAX : y + stp;
        else ny = y;
      end else begin
        m_hold[k] = 0;
        m_dir[k]  = 0;
        tgt = int'(ball) - PH / 2;
        if (tgt < 0) tgt = 0;
        if (tgt > YMAX) tgt = YMAX;
        if (tgt > y) ny = y + ((tgt - y < AI_SPEED) ? tgt - y : AI_SPEED);
        else ny = y - ((y - tgt < AI_SPEED) ? y - tgt : AI_SPEED);
      end
      nxt_y[k]   = ny;
      nxt_mov[k] = (ny != y);
    end
  endtask

  initial begin : model_and_compare
    bit busy_prev, exp_busy;
    e = 0; e0 = 0; sweeping = 0; m_ovr = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NP; i++) begin
          m_y[i] = YRST; m_mov[i] = 0; m_hold[i] = 0; m_dir[i] = 0;
        end
        m_ovr = 0; sweeping = 0;
        up_h1 = '0; up_h2 = '0; dn_h1 = '0; dn_h2 = '0; ac_h1 = '0; ac_h2 = '0;
      end else begin
        e++;
        if (sweeping && e > e0 && e <= e0 + NP) begin
          m_y[e - e0 - 1]   = nxt_y[e - e0 - 1];
          m_mov[e - e0 - 1] = nxt_mov[e - e0 - 1];
        end
        busy_prev = sweeping && (e - 1 >= e0) && (e - 1 < e0 + NP);
        if (tick) begin
          if (busy_prev) m_ovr = 1;
          else begin
            e0 = e; sweeping = 1;
            plan_frame();
          end
        end
        up_h2 = up_h1; up_h1 = up;
        dn_h2 = dn_h1; dn_h1 = down;
        ac_h2 = ac_h1; ac_h1 = active;
      end
      #2;
      exp_busy = sweeping && (e >= e0) && (e < e0 + NP);
      for (int i = 0; i < NP; i++) begin
        check($sformatf("y%0d", i), y_of(i), m_y[i]);
        check($sformatf("moving%0d", i), int'(moving[i]), int'(m_mov[i]));
      end
      check("busy", int'(busy), int'(exp_busy));
      check("overrun", int'(overrun), int'(m_ovr));
      check("state", int'(dbg_state), exp_busy ? int'(ST_SWEEP) : int'(ST_IDLE));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_in(logic [NP-1:0] u, logic [NP-1:0] d, logic [NP-1:0] a);
    @(negedge clk);
    up = u; down = d; active = a;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (NP + 2) @(negedge clk);
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stimulus
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < NP; k++) check("rst_y", y_of(k), 208);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // Human up on ch0
    set_in(4'b0001, 4'b0000, 4'b1111);
    exp_q = {10'd204, 10'd200, 10'd196};
    while (exp_q.size() > 0) begin
      frame();
      check("human_up_y0", y_of(0), int'(exp_q.pop_front()));
      check("human_up_mov0", int'(moving[0]), 1);
    end

    // Both buttons: hold
    set_in(4'b0001, 4'b0001, 4'b1111);
    frame();
    check("both_y0", y_of(0), 196);
    check("both_mov0", int'(moving[0]), 0);

    // Held down on ch0 from 208
    do_reset();
    set_in(4'b0000, 4'b0001, 4'b1111);
`ifdef SPHN_PADDLE_ACCEL_EN
    exp_q = {10'd212, 10'd217, 10'd223, 10'd230, 10'd238, 10'd246};
`else
    exp_q = {10'd212, 10'd216, 10'd220, 10'd224, 10'd228, 10'd232};
`endif
    while (exp_q.size() > 0) begin
      frame();
      check("down_ramp_y0", y_of(0), int'(exp_q.pop_front()));
    end

    // AI tracking on ch1
    do_reset();
    ball = 10'd100;
    set_in(4'b0000, 4'b0000, 4'b1101);
    frame(); check("ai_y1_a", y_of(1), 205);
    frame(); check("ai_y1_b", y_of(1), 202);
    frames(44); check("ai_y1_c", y_of(1), 70);
    frame(); check("ai_y1_d", y_of(1), 68); check("ai_mov1_d", int'(moving[1]), 1);
    frame(); check("ai_y1_e", y_of(1), 68); check("ai_mov1_e", int'(moving[1]), 0);

    // Bottom clamp: bring ch1 to 414, then hold down
    do_reset();
    set_in(4'b0000, 4'b0010, 4'b1111);
    frames(50); check("clamp_pre_y1", y_of(1), 408);
    ball = 10'd479;
    set_in(4'b0000, 4'b0010, 4'b1101);
    frames(2); check("clamp_ai_y1", y_of(1), 414);
    set_in(4'b0000, 4'b0010, 4'b1111);
    exp_q = {10'd416, 10'd416, 10'd416};
    for (int i = 0; i < 3; i++) begin
      frame();
      check("clamp_dn_y1", y_of(1), int'(exp_q.pop_front()));
      check("clamp_dn_mov1", int'(moving[1]), (i == 0) ? 1 : 0);
    end

    // Top clamp from y=2
    ball = 10'd34;
    set_in(4'b0000, 4'b0000, 4'b1101);
    frames(140); check("clamp_up_pre_y1", y_of(1), 2);
    set_in(4'b0010, 4'b0000, 4'b1111);
    frame(); check("clamp_up_y1_a", y_of(1), 0); check("clamp_up_mov1", int'(moving[1]), 1);
    frame(); check("clamp_up_y1_b", y_of(1), 0);

    // Overrun and per-channel latency
    do_reset();
    set_in(4'b1111, 4'b0000, 4'b1111);
    @(negedge clk); tick = 1'b1;
    @(negedge clk);
    check("lat_busy", int'(busy), 1);
    check("lat_y0_old", y_of(0), 208);
    check("lat_ovr_pre", int'(overrun), 0);
    @(negedge clk); tick = 1'b0;
    check("ovr_set", int'(overrun), 1);
    check("lat_y0_new", y_of(0), 204); check("lat_y1_old", y_of(1), 208);
    @(negedge clk);
    check("lat_y1_new", y_of(1), 204); check("lat_y2_old", y_of(2), 208);
    @(negedge clk);
    check("lat_y2_new", y_of(2), 204); check("lat_y3_old", y_of(3), 208);
    @(negedge clk);
    check("lat_y3_new", y_of(3), 204); check("lat_busy_end", int'(busy), 0);
    repeat (4) @(negedge clk);
    check("ovr_ignored_y0", y_of(0), 204);
    check("ovr_sticky", int'(overrun), 1);

    // Reset in the middle of a sweep
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NP; k++) check("midrst_y", y_of(k), 208);
    check("midrst_state", int'(dbg_state), int'(ST_IDLE));
    check("midrst_busy", int'(busy), 0);
    check("midrst_ovr", int'(overrun), 0);
    check("midrst_mov", int'(moving), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Randomised traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) begin
        up     = NP'($urandom);
        down   = NP'($urandom);
        active = NP'($urandom);
      end
      ball = Y_W'($urandom_range(0, 1023));
    end
    @(negedge clk); tick = 1'b0;
    repeat (NP + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
